dmem_io_bridge: RTL and testbench

- Data-side bus bridge between the single-cycle CPU data port (ALU address, write data, write/read strobes) and the data memory (DMEM).
- Decodes each CPU data access into one of two targets: the DMEM window, converted to an 11-bit word index, or a small memory-mapped I/O page.
- The I/O page contains a transmit FIFO with a valid/ready output stream, a free-running cycle counter, and a compare interrupt.
- Replaces the bare address-subtract path at the top level; DMEM keeps its existing port set.

---
 rtl/dmem_io_bridge_if.sv | 27 ++
 rtl/dmem_io_bridge.sv | 85 ++++++++
 tb/tb_dmem_io_bridge.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_bridge_if.sv
// dmem_io_bridge_if: CPU data port, DMEM port and TX stream bundle
interface dmem_io_bridge_if;
  logic        ena;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_w;
  logic        cpu_r;
  logic [31:0] cpu_rdata;
  logic [10:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] dm_rdata;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;
  logic        bus_err;
  modport slave (
    input  ena, cpu_addr, cpu_wdata, cpu_w, cpu_r, dm_rdata, tx_ready,
    output cpu_rdata, dm_addr, dm_wdata, dm_w, dm_r, tx_data, tx_valid, timer_irq, bus_err
  );
  modport master (
    output ena, cpu_addr, cpu_wdata, cpu_w, cpu_r, dm_rdata, tx_ready,
    input  cpu_rdata, dm_addr, dm_wdata, dm_w, dm_r, tx_data, tx_valid, timer_irq, bus_err
  );
endinterface

// File: rtl/dmem_io_bridge.sv
// dmem_io_bridge: decodes CPU data accesses into DMEM window or I/O page (TX FIFO, counter, compare irq)
module dmem_io_bridge #(
  parameter logic [31:0] DMEM_BASE  = 32'h1001_0000,
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] IO_BASE    = 32'h1001_F000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  dmem_io_bridge_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] off, status, io_rdata;
  logic        in_dm, in_io;
  logic [3:0]  io_off;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] ctr_q, ctr_d, cmp_q, cmp_d;
  logic        irq_q, irq_d, ovf_q, ovf_d, err_q, err_d;
  logic        wr_tx, wr_ctr, wr_cmp, wr_clr, full, empty, push, pop, drop, hit;
  assign off    = bus.cpu_addr - DMEM_BASE;
  assign in_dm  = off < 32'(4 * DMEM_WORDS);
  assign in_io  = bus.cpu_addr[31:6] == IO_BASE[31:6];
  assign io_off = bus.cpu_addr[5:2];
  assign bus.dm_addr  = off[12:2];
  assign bus.dm_wdata = bus.cpu_wdata;
  assign bus.dm_w     = bus.cpu_w & in_dm & bus.ena & reset;
  assign bus.dm_r     = bus.cpu_r & in_dm;
  assign status       = {21'd0, err_q, ovf_q, irq_q, 6'(cnt_q), empty, full};
  assign io_rdata     = io_off == 4'd1 ? status : io_off == 4'd2 ? ctr_q : io_off == 4'd3 ? cmp_q : '0;
  assign bus.cpu_rdata = in_dm ? bus.dm_rdata : in_io ? io_rdata : '0;
  // the FIFO array carries no reset, so an empty FIFO masks its stale head to 0
  assign bus.tx_valid  = !empty;
  assign bus.tx_data   = empty ? '0 : mem_q[rp_q];
  assign bus.timer_irq = irq_q;
  assign bus.bus_err   = err_q;
  // next-state for FIFO pointers, counter, compare and sticky flags
  always_comb begin
    wr_tx  = bus.cpu_w & in_io & (io_off == 4'd0);
    wr_ctr = bus.cpu_w & in_io & (io_off == 4'd2);
    wr_cmp = bus.cpu_w & in_io & (io_off == 4'd3);
    wr_clr = bus.cpu_w & in_io & (io_off == 4'd4);
    full   = cnt_q == (AW+1)'(FIFO_DEPTH);
    empty  = cnt_q == '0;
    pop    = !empty & bus.tx_ready;
    push   = wr_tx & (!full | pop);
    drop   = wr_tx & full & !pop;
    hit    = (ctr_q == cmp_q) && (cmp_q != '0);
    wp_d   = wp_q + AW'(push);
    rp_d   = rp_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    ctr_d  = wr_ctr ? bus.cpu_wdata : ctr_q + 32'd1;
    cmp_d  = wr_cmp ? bus.cpu_wdata : cmp_q;
    irq_d  = hit | (irq_q & !wr_clr);
    ovf_d  = drop | (ovf_q & !wr_clr);
    err_d  = err_q | ((bus.cpu_w | bus.cpu_r) & !in_dm & !in_io);
  end
  // state registers: reset clears everything, ena=0 freezes
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ctr_q <= '0;
      cmp_q <= '0;
      irq_q <= 1'b0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else if (bus.ena) begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ctr_q <= ctr_d;
      cmp_q <= cmp_d;
      irq_q <= irq_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  // FIFO storage write
  always_ff @(posedge clk) begin
    if (reset && bus.ena && push) mem_q[wp_q] <= bus.cpu_wdata;
  end
endmodule

// File: tb/tb_dmem_io_bridge.sv
// tb_dmem_io_bridge: random + directed stimulus against a queue-based reference model with a TX scoreboard
module tb_dmem_io_bridge;
  localparam logic [31:0] DB  = 32'h1001_0000;
  localparam logic [31:0] IOB = 32'h1001_F000;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_io_bridge_if bus ();
  dmem_io_bridge dut (.clk(clk), .reset(rst_n), .bus(bus));
  logic [31:0] dmem [2048];
  assign bus.dm_rdata = dmem[bus.dm_addr];
  int checks = 0;
  int errors = 0;
  logic [31:0] m_fifo [$];
  logic [31:0] sb_q [$];
  logic [31:0] refm [int];
  logic [31:0] m_ctr, m_cmp;
  bit m_irq, m_ovf, m_err;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  function automatic bit is_dm(logic [31:0] a);
    return a >= DB && a < DB + 32'd8192;
  endfunction
  function automatic bit is_io(logic [31:0] a);
    return a >= IOB && a < IOB + 32'd64;
  endfunction
  function automatic int io_word(logic [31:0] a);
    return int'((a - IOB) / 4);
  endfunction
  function automatic logic [31:0] rd_exp(logic [31:0] a);
    int idx;
    int n;
    if (is_dm(a)) begin
      idx = int'((a - DB) / 4);
      return refm.exists(idx) ? refm[idx] : 32'd0;
    end
    if (!is_io(a)) return 32'd0;
    n = m_fifo.size();
    case (io_word(a))
      1: return (n == DEPTH ? 32'd1 : 32'd0) + (n == 0 ? 32'd2 : 32'd0) + 32'(n * 4)
                + (m_irq ? 32'd256 : 32'd0) + (m_ovf ? 32'd512 : 32'd0) + (m_err ? 32'd1024 : 32'd0);
      2: return m_ctr;
      3: return m_cmp;
      default: return 32'd0;
    endcase
  endfunction
  function automatic void model(logic [31:0] a, logic [31:0] d, bit w, bit r, bit rdy, bit en, bit rs);
    bit io, dm, hit, clr, popped, was_full, ovf_set;
    if (!rs) begin
      m_fifo.delete();
      sb_q.delete();
      m_ctr = 0; m_cmp = 0; m_irq = 0; m_ovf = 0; m_err = 0;
      return;
    end
    if (!en) return;
    io = is_io(a);
    dm = is_dm(a);
    hit = (m_ctr == m_cmp) && (m_cmp != 0);
    clr = w && io && io_word(a) == 4;
    ovf_set = 0;
    if (w && dm) refm[int'((a - DB) / 4)] = d;
    was_full = m_fifo.size() == DEPTH;
    popped = m_fifo.size() > 0 && rdy;
    if (popped) void'(m_fifo.pop_front());
    if (w && io && io_word(a) == 0) begin
      if (!was_full || popped) begin
        m_fifo.push_back(d);
        sb_q.push_back(d);
      end else ovf_set = 1;
    end
    m_irq = hit || (m_irq && !clr);
    m_ovf = ovf_set || (m_ovf && !clr);
    m_ctr = (w && io && io_word(a) == 2) ? d : m_ctr + 1;
    if (w && io && io_word(a) == 3) m_cmp = d;
    if ((w || r) && !io && !dm) m_err = 1;
  endfunction
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit w, input bit r,
                      input bit rdy, input bit en, input bit rs);
    logic [31:0] exp_idx;
    bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_w = w; bus.cpu_r = r;
    bus.tx_ready = rdy; bus.ena = en; rst_n = rs;
    exp_idx = ((a - DB) / 4) % 2048;
    @(negedge clk);
    chk("cpu_rdata", bus.cpu_rdata, rd_exp(a));
    chk("dm_w", 32'(bus.dm_w), 32'(w && is_dm(a) && en && rs));
    chk("dm_r", 32'(bus.dm_r), 32'(r && is_dm(a)));
    chk("dm_addr", 32'(bus.dm_addr), exp_idx);
    chk("dm_wdata", bus.dm_wdata, d);
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
    chk("tx_data", bus.tx_data, m_fifo.size() != 0 ? m_fifo[0] : 32'd0);
    chk("timer_irq", 32'(bus.timer_irq), 32'(m_irq));
    chk("bus_err", 32'(bus.bus_err), 32'(m_err));
    @(posedge clk);
    if (bus.dm_w) dmem[bus.dm_addr] = bus.dm_wdata;
    model(a, d, w, r, rdy, en, rs);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit rdy);
    step(a, d, 1, 0, rdy, 1, 1);
  endtask
  task automatic rd(input logic [31:0] a, input bit rdy);
    step(a, 32'd0, 0, 1, rdy, 1, 1);
  endtask
  task automatic idle(input bit rdy);
    step(32'd0, 32'd0, 0, 0, rdy, 1, 1);
  endtask
  // TX scoreboard monitor: every accepted beat must match the oldest queued push
  always @(negedge clk) begin
    if (rst_n && bus.ena && bus.tx_valid && bus.tx_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_pop: got %h with nothing expected", bus.tx_data);
      end else chk("tx_beat", bus.tx_data, sb_q.pop_front());
    end
  end
  initial begin
    logic [31:0] a, d;
    int op;
    for (int i = 0; i < 2048; i++) dmem[i] = 32'd0;
    bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_w = 0; bus.cpu_r = 0;
    bus.tx_ready = 0; bus.ena = 1; rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model(0, 0, 0, 0, 0, 1, 0);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_tx_data", bus.tx_data, 32'd0);
    wr(DB + 32'd8, 32'hDEAD_BEEF, 0);
    chk("dm_addr_2", 32'(bus.dm_addr), 32'd2);
    rd(DB + 32'd8, 0);
    chk("dm_load", bus.cpu_rdata, 32'hDEAD_BEEF);
    wr(DB + 32'h1FFC, 32'h55, 0);
    chk("dm_addr_top", 32'(bus.dm_addr), 32'd2047);
    for (int v = 1; v <= 4; v++) wr(IOB, 32'(v), 0);
    rd(IOB + 32'd4, 0);
    chk("status_full", 32'(bus.cpu_rdata[7:0]), 32'h11);
    wr(IOB, 32'd5, 0);
    rd(IOB + 32'd4, 0);
    chk("status_ovf", 32'(bus.cpu_rdata[9]), 32'd1);
    repeat (5) idle(1);
    chk("drained", 32'(bus.tx_valid), 32'd0);
    wr(IOB + 32'h10, 32'd0, 0);
    for (int v = 5; v <= 8; v++) wr(IOB, 32'(v), 0);
    wr(IOB, 32'd9, 1);
    rd(IOB + 32'd4, 0);
    chk("full_push_pop", 32'(bus.cpu_rdata[9:0]), 32'h011);
    repeat (5) idle(1);
    wr(IOB + 32'hC, 32'd20, 0);
    wr(IOB + 32'h8, 32'd10, 0);
    repeat (10) idle(0);
    chk("irq_not_yet", 32'(bus.timer_irq), 32'd0);
    idle(0);
    chk("irq_rise", 32'(bus.timer_irq), 32'd1);
    wr(IOB + 32'h10, 32'd0, 0);
    chk("irq_clr", 32'(bus.timer_irq), 32'd0);
    wr(IOB + 32'hC, 32'd50, 0);
    wr(IOB + 32'h8, 32'd49, 0);
    idle(0);
    wr(IOB + 32'h10, 32'd0, 0);
    chk("irq_set_wins", 32'(bus.timer_irq), 32'd1);
    wr(IOB + 32'h10, 32'd0, 0);
    rd(32'h40, 0);
    chk("bus_err_rd", 32'(bus.bus_err), 32'd1);
    wr(32'h2000_0000, 32'h1234, 0);
    rd(IOB + 32'd4, 0);
    chk("status_err", 32'(bus.cpu_rdata[10]), 32'd1);
    step(IOB, 32'd77, 1, 0, 1, 0, 1);
    wr(IOB + 32'h8, 32'h122F, 0);
    wr(IOB + 32'hC, 32'h1230, 0);
    idle(0);
    for (int v = 1; v <= 3; v++) wr(IOB, 32'(v), 0);
    step(IOB + 32'h8, 32'd0, 0, 1, 0, 1, 0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_irq", 32'(bus.timer_irq), 32'd0);
    chk("rst_counter", bus.cpu_rdata, 32'd0);
    rd(IOB + 32'h8, 0);
    chk("counter_resume", bus.cpu_rdata, 32'd1);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: a = DB + 32'(4 * $urandom_range(0, 15));
        1: a = $urandom_range(0, 1) ? DB + 32'h1FFC : DB + 32'h2000;
        2, 3: a = IOB + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      d = (is_io(a) && io_word(a) == 3) ? m_ctr + 32'($urandom_range(1, 8)) : $urandom;
      op = $urandom_range(0, 2);
      step(a, d, op == 1, op == 2, $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
           $urandom_range(0, 49) != 0);
    end
    repeat (6) idle(1);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
